updown_counter: RTL and testbench

Parametrised up/down counter with programmable modulus, wrap or saturate mode, synchronous load and sticky overflow/underflow flags. It is the generalised successor to the fixed 4-bit up-counter and serves as the common event/interval counter for timers and watchdogs in the design. All state is registered on `clk`.

---
 rtl/counter_pkg.sv | 19 +
 rtl/counter_prescaler.sv | 33 +++
 rtl/updown_counter.sv | 105 ++++++++++
 tb/tb_updown_counter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family (mode, direction, default terminal count).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package counter_pkg;

  // Overflow/underflow handling at the count bounds
  localparam int CNT_MODE_WRAP = 0;
  localparam int CNT_MODE_SAT  = 1;

  // Meaning of the up_down input
  localparam logic CNT_DIR_DOWN = 1'b0;
  localparam logic CNT_DIR_UP   = 1'b1;

  // Largest value representable in 'width' bits; the natural terminal count
  function automatic int cnt_default_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler: emits a tick on every DIV-th cycle with enable high, then restarts its phase.
// Latency: tick is combinational from the current phase and enable; the phase updates on clk.
// Backpressure: none; enable low freezes the phase, clear zeroes it.
module counter_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  // DIV=1 still needs a 1-bit phase so the declarations stay legal
  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] phase;

  assign tick = enable && (phase == LAST);

  // Phase advances on enabled cycles, wraps on the tick, and clear takes priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (clear || tick) begin
      phase <= '0;
    end else if (enable) begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with programmable modulus, wrap/saturate, load and sticky over/underflow flags.
// Latency: load, step and flag updates visible one clk after sampling; tc_out pulses with the flag set.
// Backpressure: none; load beats step beats hold. Optional prescaler under UPDOWN_COUNTER_PRESCALE_EN.
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int STEP         = 1,
  parameter int MAX_VALUE    = cnt_default_max(WIDTH),
  parameter int SAT_MODE     = CNT_MODE_WRAP,
  parameter int PRESCALE_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] counter_out,
  output logic             overflow_out,
  output logic             underflow_out,
  output logic             tc_out
);

  // Parameter sanity checks, caught at elaboration
  if (WIDTH < 2)                                  $error("updown_counter: WIDTH must be >= 2");
  if (MAX_VALUE < 1 || MAX_VALUE > cnt_default_max(WIDTH)) $error("updown_counter: MAX_VALUE out of range");
  if (STEP < 1 || STEP > MAX_VALUE)               $error("updown_counter: STEP out of range");
  if (PRESCALE_DIV < 1)                           $error("updown_counter: PRESCALE_DIV must be >= 1");

  // One extra bit so an up step past the top never aliases back into range
  localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX_VALUE);
  localparam logic             SAT    = (SAT_MODE != CNT_MODE_WRAP);

  logic             tick;
  logic             do_step;
  logic [WIDTH:0]   cur_w;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] nxt_cnt;
  logic             ov_evt;
  logic             un_evt;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  counter_prescaler #(
    .DIV (PRESCALE_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (load),
    .tick   (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign do_step = enable && !load && tick;
  assign cur_w   = {1'b0, counter_out};
  assign sum_w   = cur_w + STEP_W;

  // Next count and bound events; events only fire on a real step
  always_comb begin
    nxt_cnt = counter_out;
    ov_evt  = 1'b0;
    un_evt  = 1'b0;
    if (load) begin
      nxt_cnt = ({1'b0, load_value} > MAX_W) ? MAX_N : load_value;
    end else if (do_step) begin
      if (up_down == CNT_DIR_UP) begin
        if (sum_w <= MAX_W) begin
          nxt_cnt = WIDTH'(sum_w);
        end else begin
          ov_evt  = 1'b1;
          nxt_cnt = SAT ? MAX_N : WIDTH'(sum_w - MAX_W - 1'b1);
        end
      end else begin
        if (cur_w >= STEP_W) begin
          nxt_cnt = WIDTH'(cur_w - STEP_W);
        end else begin
          un_evt  = 1'b1;
          nxt_cnt = SAT ? '0 : WIDTH'(cur_w + MAX_W + 1'b1 - STEP_W);
        end
      end
    end
  end

  // Count, sticky flags (a new event beats clear_flags) and the one-cycle tc pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_out   <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
      tc_out        <= 1'b0;
    end else begin
      counter_out   <= nxt_cnt;
      overflow_out  <= ov_evt || (overflow_out && !clear_flags);
      underflow_out <= un_evt || (underflow_out && !clear_flags);
      tc_out        <= ov_evt || un_evt;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three configurations driven with shared random stimulus.
// Latency: expected state is queued at drive time and popped one edge later.
// Backpressure: n/a.
module tb_updown_counter;

  localparam int NI  = 3;
  localparam int DIV = 4;
  // Per-instance configuration: default wrap, mod-10 step-3 wrap, saturating
  localparam int P_MAX  [NI] = '{15, 9, 15};
  localparam int P_STEP [NI] = '{1, 3, 1};
  localparam int P_SAT  [NI] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic       clear_flags = 1'b0;

  logic [3:0] cnt_o [NI];
  logic       ov_o  [NI];
  logic       un_o  [NI];
  logic       tc_o  [NI];

  typedef struct packed {
    logic [NI-1:0][3:0] cnt;
    logic [NI-1:0]      ov;
    logic [NI-1:0]      un;
    logic [NI-1:0]      tc;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int m_cnt [NI];
  int m_ph  [NI];
  bit m_ov  [NI];
  bit m_un  [NI];
  bit m_tc  [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .STEP(1), .MAX_VALUE(15), .SAT_MODE(0), .PRESCALE_DIV(DIV)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear_flags(clear_flags), .counter_out(cnt_o[0]),
    .overflow_out(ov_o[0]), .underflow_out(un_o[0]), .tc_out(tc_o[0]));

  updown_counter #(.WIDTH(4), .STEP(3), .MAX_VALUE(9), .SAT_MODE(0), .PRESCALE_DIV(DIV)) u_mod9 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear_flags(clear_flags), .counter_out(cnt_o[1]),
    .overflow_out(ov_o[1]), .underflow_out(un_o[1]), .tc_out(tc_o[1]));

  updown_counter #(.WIDTH(4), .STEP(1), .MAX_VALUE(15), .SAT_MODE(1), .PRESCALE_DIV(DIV)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear_flags(clear_flags), .counter_out(cnt_o[2]),
    .overflow_out(ov_o[2]), .underflow_out(un_o[2]), .tc_out(tc_o[2]));

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_ph[i] = 0; m_ov[i] = 0; m_un[i] = 0; m_tc[i] = 0;
    end
  endtask

  // Drive one cycle of inputs and queue the state the DUTs should show after the next edge
  task automatic drive(input logic en, input logic ud, input logic ld,
                       input logic [3:0] lv, input logic cf);
    exp_t e;
    int   n;
    bit   tick;
    bit   ov_e;
    bit   un_e;
    @(negedge clk);
    enable = en; up_down = ud; load = ld; load_value = lv; clear_flags = cf;
    e = '0;
    for (int i = 0; i < NI; i++) begin
      ov_e = 0;
      un_e = 0;
      if (ld) begin
        m_cnt[i] = (int'(lv) > P_MAX[i]) ? P_MAX[i] : int'(lv);
        m_ph[i]  = 0;
      end else if (en) begin
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        m_ph[i] = m_ph[i] + 1;
        tick = (m_ph[i] == DIV);
        if (tick) m_ph[i] = 0;
`else
        tick = 1;
`endif
        if (tick) begin
          if (ud) begin
            n = m_cnt[i] + P_STEP[i];
            if (n > P_MAX[i]) begin
              ov_e = 1;
              n = (P_SAT[i] != 0) ? P_MAX[i] : n - (P_MAX[i] + 1);
            end
          end else begin
            n = m_cnt[i] - P_STEP[i];
            if (n < 0) begin
              un_e = 1;
              n = (P_SAT[i] != 0) ? 0 : n + P_MAX[i] + 1;
            end
          end
          m_cnt[i] = n;
        end
      end
      m_ov[i] = ov_e || (m_ov[i] && !cf);
      m_un[i] = un_e || (m_un[i] && !cf);
      m_tc[i] = ov_e || un_e;
      e.cnt[i] = 4'(m_cnt[i]);
      e.ov[i]  = m_ov[i];
      e.un[i]  = m_un[i];
      e.tc[i]  = m_tc[i];
    end
    sb.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle; compare against the queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < NI; i++) begin
        chk("counter_out", i, int'(cnt_o[i]), int'(e.cnt[i]));
        chk("overflow_out", i, int'(ov_o[i]), int'(e.ov[i]));
        chk("underflow_out", i, int'(un_o[i]), int'(e.un[i]));
        chk("tc_out", i, int'(tc_o[i]), int'(e.tc[i]));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_cnt"}, i, int'(cnt_o[i]), 0);
      chk({tag, "_ov"},  i, int'(ov_o[i]),  0);
      chk({tag, "_un"},  i, int'(un_o[i]),  0);
      chk({tag, "_tc"},  i, int'(tc_o[i]),  0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic en, ud, ld, cf;
    logic [3:0] lv;

    model_reset();
    #1 reset = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Long up run from 0: wraps, repeated saturation events
    drive(0, 1, 1, 4'd0, 0);
    for (int k = 0; k < 70; k++) drive(1, 1, 0, 4'd0, 0);
    // Load clamp to MAX_VALUE, then clear_flags coincident with an overflow
    drive(1, 1, 1, 4'd12, 0);
    for (int k = 0; k < DIV; k++) drive(1, 1, 0, 4'd0, (k == DIV - 1));
    // Down run with enable gaps that must not shift the tick positions
    for (int k = 0; k < 60; k++) drive((k % 3) != 1, 0, 0, 4'd0, 0);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      en = ($urandom_range(0, 99) < 80);
      ud = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 99) < 8);
      lv = 4'($urandom_range(0, 15));
      cf = !ld && ($urandom_range(0, 99) < 5);
      drive(en, ud, ld, lv, cf);
    end

    // Set both flags, park at 7, then reset between edges
    drive(0, 0, 1, 4'd0, 0);
    for (int k = 0; k < DIV; k++) drive(1, 0, 0, 4'd0, 0);
    drive(0, 1, 1, 4'd15, 0);
    for (int k = 0; k < DIV; k++) drive(1, 1, 0, 4'd0, 0);
    drive(0, 0, 1, 4'd7, 0);
    @(negedge clk);
    enable = 1'b0; load = 1'b0;
    @(posedge clk);
    #3;
    for (int i = 0; i < NI; i++) chk("pre_reset_cnt", i, int'(cnt_o[i]), 7);
    reset = 1'b1;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Counting resumes normally after reset
    for (int k = 0; k < 20; k++) drive(1, 1, 0, 4'd0, 0);
    drive(0, 0, 0, 4'd0, 0);
    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
